zumbador_multi: RTL and testbench

Parametrised multi-channel AXI4-Lite buzzer peripheral, successor to the single-channel zumbador register block. Each of NUM_CH channels generates a square wave with a programmable half-period and an optional burst length measured in full periods. Completion is reported through sticky done bits and a level interrupt. The block sits behind the PS AXI interconnect as an AXI4-Lite slave and drives the board buzzer pins.

---
 rtl/zumbador_multi.sv | 252 +++++++++++++++++++++++++
 tb/tb_zumbador_multi.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/zumbador_multi.sv
// Multi-channel AXI4-Lite buzzer: NUM_CH square-wave generators with programmable
// half-period, burst length in full periods, sticky DONE bits and a level interrupt.

module zumbador_ch #(
   parameter int CNT_WIDTH = 24
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 gen_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic [CNT_WIDTH-1:0] half_i,
   input  logic [CNT_WIDTH-1:0] dur_i,
   output logic                 buzz_o,
   output logic                 busy_o,
   output logic                 done_o
);
   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   state_t               st_q, st_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [CNT_WIDTH-1:0] reload;

   // HALF may be rewritten to 0 mid-tone; clamp so the counter never wraps
   assign reload = (half_i == '0) ? '0 : half_i - CNT_WIDTH'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q  <= S_IDLE;
         cnt_q <= '0;
         rem_q <= '0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         rem_q <= rem_d;
      end
   end

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      done_o = 1'b0;
      if (stop_i || !gen_i) begin
         st_d = S_IDLE;
      end else if (start_i && half_i != '0) begin
         st_d  = S_HIGH;
         cnt_d = reload;
         rem_d = dur_i;
      end else begin
         case (st_q)
            S_HIGH: begin
               if (cnt_q == '0) begin
                  st_d  = S_LOW;
                  cnt_d = reload;
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
            S_LOW: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end else if (rem_q == CNT_WIDTH'(1)) begin
                  st_d   = S_IDLE;
                  done_o = 1'b1;
               end else begin
                  // rem_q == 0 means continuous: never decrement it
                  st_d  = S_HIGH;
                  cnt_d = reload;
                  if (rem_q != '0) rem_d = rem_q - CNT_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign buzz_o = (st_q == S_HIGH);
   assign busy_o = (st_q != S_IDLE);
endmodule

module zumbador_multi #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int NUM_CH             = 4,
   parameter int CNT_WIDTH          = 24
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_CH-1:0]               buzz_out,
   output logic                            irq
);
   localparam int WA = C_S_AXI_ADDR_WIDTH - 2;
   typedef logic [WA-1:0] wa_t;

   logic                            awready_q, awready_d;
   logic                            bvalid_q, bvalid_d;
   logic                            arready_q, arready_d;
   logic                            rvalid_q, rvalid_d;
   logic [31:0]                     rdata_q, rdata_d;
   logic                            gen_q, gen_d, ien_q, ien_d;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] half_q, half_d, dur_q, dur_d;
   logic [NUM_CH-1:0]               done_q, done_d, done_set, done_clr;
   logic [NUM_CH-1:0]               start, stop, busy;
   logic                            irq_q;
   logic                            wr_hs, rd_hs;
   wa_t                             wa, ra;
   logic                            unused_ok;

   assign wa    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign ra    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign wr_hs = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_hs = arready_q & S_AXI_ARVALID;

   function automatic logic [CNT_WIDTH-1:0] merge(input logic [CNT_WIDTH-1:0] old,
                                                  input logic [31:0] wd,
                                                  input logic [3:0] st);
      logic [31:0] o;
      o = 32'(old);
      for (int b = 0; b < 4; b++)
         if (st[b]) o[8*b +: 8] = wd[8*b +: 8];
      return o[CNT_WIDTH-1:0];
   endfunction

   always_comb begin
      awready_d = ~awready_q & ~bvalid_q & S_AXI_AWVALID & S_AXI_WVALID;
      bvalid_d  = wr_hs ? 1'b1 : (S_AXI_BREADY ? 1'b0 : bvalid_q);
      arready_d = ~arready_q & ~rvalid_q & S_AXI_ARVALID;
      rvalid_d  = rd_hs ? 1'b1 : (S_AXI_RREADY ? 1'b0 : rvalid_q);
   end

   // register file write decode; CMD and DONE produce one-cycle strobes
   always_comb begin
      gen_d    = gen_q;
      ien_d    = ien_q;
      half_d   = half_q;
      dur_d    = dur_q;
      start    = '0;
      stop     = '0;
      done_clr = '0;
      if (wr_hs) begin
         if (wa == wa_t'(0) && S_AXI_WSTRB[0]) begin
            gen_d = S_AXI_WDATA[0];
            ien_d = S_AXI_WDATA[1];
         end
         if (wa == wa_t'(1) && S_AXI_WSTRB[1]) done_clr = S_AXI_WDATA[8 +: NUM_CH];
         for (int c = 0; c < NUM_CH; c++) begin
            if (wa == wa_t'(4*(c+1)))
               half_d[c] = merge(half_q[c], S_AXI_WDATA, S_AXI_WSTRB);
            if (wa == wa_t'(4*(c+1)+1))
               dur_d[c] = merge(dur_q[c], S_AXI_WDATA, S_AXI_WSTRB);
            if (wa == wa_t'(4*(c+1)+2) && S_AXI_WSTRB[0]) begin
               start[c] = S_AXI_WDATA[0];
               stop[c]  = S_AXI_WDATA[1];
            end
         end
      end
      done_d = (done_q & ~done_clr) | done_set;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_hs) begin
         rdata_d = '0;
         if (ra == wa_t'(0)) rdata_d[1:0] = {ien_q, gen_q};
         if (ra == wa_t'(1)) begin
            rdata_d[NUM_CH-1:0]   = busy;
            rdata_d[8 +: NUM_CH]  = done_q;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (ra == wa_t'(4*(c+1)))   rdata_d[CNT_WIDTH-1:0] = half_q[c];
            if (ra == wa_t'(4*(c+1)+1)) rdata_d[CNT_WIDTH-1:0] = dur_q[c];
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         gen_q     <= 1'b0;
         ien_q     <= 1'b0;
         half_q    <= '0;
         dur_q     <= '0;
         done_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         gen_q     <= gen_d;
         ien_q     <= ien_d;
         half_q    <= half_d;
         dur_q     <= dur_d;
         done_q    <= done_d;
         irq_q     <= ien_q & (|done_q);
      end
   end

   // gen_d lets a GEN=0 write kill channels on the same edge as a STOP
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      zumbador_ch #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
         .clk_i   (ACLK),
         .rst_ni  (ARESETN),
         .gen_i   (gen_d),
         .start_i (start[c]),
         .stop_i  (stop[c]),
         .half_i  (half_q[c]),
         .dur_i   (dur_q[c]),
         .buzz_o  (buzz_out[c]),
         .busy_o  (busy[c]),
         .done_o  (done_set[c])
      );
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = awready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = 2'b00;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;
   assign irq           = irq_q;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_zumbador_multi.sv
// Directed bench for zumbador_multi: register table readback plus tone, burst,
// stop, gating and asynchronous-reset sequences.

module tb_zumbador_multi;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  awaddr = '0, araddr = '0;
   logic [2:0]  awprot = '0, arprot = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bready = 1'b1, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [3:0]  buzz;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   zumbador_multi dut (
      .ACLK(clk), .ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .buzz_out(buzz), .irq(irq)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // returns at the falling edge of the first cycle after the handshake edge
   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 20);
      if (!awready) chk("wr_timeout", {31'd0, awready}, 32'd1);
      else @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 20);
      if (!arready) chk("rd_timeout", {31'd0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      d = rvalid ? rdata : 32'hDEAD_BEEF;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic rchk(input string name, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(name, d, exp);
   endtask

   vec_t tbl[13];
   logic [31:0] rv;

   initial begin
      tbl[0]  = '{8'h10, 32'h0000_0001, 4'hF, 32'h0000_0001};
      tbl[1]  = '{8'h14, 32'h0000_0002, 4'hF, 32'h0000_0002};
      tbl[2]  = '{8'h00, 32'h0000_0003, 4'hF, 32'h0000_0003};
      tbl[3]  = '{8'h20, 32'h0000_0004, 4'hF, 32'h0000_0004};
      tbl[4]  = '{8'h10, 32'hFFFF_FFFF, 4'hF, 32'h00FF_FFFF};
      tbl[5]  = '{8'h10, 32'hAABB_CCDD, 4'h2, 32'h00FF_CCFF};
      tbl[6]  = '{8'h10, 32'h0000_0005, 4'h0, 32'h00FF_CCFF};
      tbl[7]  = '{8'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
      tbl[8]  = '{8'h00, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000};
      tbl[9]  = '{8'h04, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000};
      tbl[10] = '{8'h50, 32'h0000_0005, 4'hF, 32'h0000_0000};
      tbl[11] = '{8'h44, 32'h0000_0007, 4'hF, 32'h0000_0007};
      tbl[12] = '{8'h18, 32'h0000_0003, 4'hF, 32'h0000_0000};

      repeat (3) @(negedge clk);
      chk("rst_outputs", {27'd0, irq, buzz}, 32'd0);
      chk("rst_handshake", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
      rst_n = 1'b1;
      rchk("rst_ctrl", 8'h00, 32'd0);
      rchk("rst_status", 8'h04, 32'd0);
      rchk("rst_half0", 8'h10, 32'd0);

      for (int i = 0; i < 13; i++) begin
         wr(tbl[i].addr, tbl[i].wdata, tbl[i].strb);
         rd(tbl[i].addr, rv);
         chk($sformatf("tbl[%0d]@%h", i, tbl[i].addr), rv, tbl[i].exp);
      end
      chk("resp_okay", {28'd0, bresp, rresp}, 32'd0);

      // burst: HALF=5, DUR=3 on ch0
      wr(8'h00, 32'd3, 4'hF);
      wr(8'h10, 32'd5, 4'hF);
      wr(8'h14, 32'd3, 4'hF);
      wr(8'h18, 32'd1, 4'h1);
      for (int i = 1; i <= 30; i++) begin
         chk($sformatf("burst_c%0d", i), {31'd0, buzz[0]}, {31'd0, ((i-1) % 10) < 5});
         @(negedge clk);
      end
      chk("burst_end_buzz_irq", {27'd0, irq, buzz}, 32'd0);
      @(negedge clk);
      chk("burst_irq_c32", {31'd0, irq}, 32'd1);
      rchk("burst_status", 8'h04, 32'h0000_0100);
      wr(8'h04, 32'h0000_0100, 4'h2);
      rchk("w1c_status", 8'h04, 32'd0);
      chk("w1c_irq", {31'd0, irq}, 32'd0);

      // continuous tone on ch1, then STOP
      wr(8'h20, 32'd2, 4'hF);
      wr(8'h24, 32'd0, 4'hF);
      wr(8'h28, 32'd1, 4'h1);
      for (int i = 1; i <= 12; i++) begin
         chk($sformatf("cont_c%0d", i), {31'd0, buzz[1]}, {31'd0, ((i-1) % 4) < 2});
         @(negedge clk);
      end
      wr(8'h28, 32'd2, 4'h1);
      chk("stop_buzz", {28'd0, buzz}, 32'd0);
      rchk("stop_status", 8'h04, 32'd0);

      // START ignored with HALF=0 or GEN=0
      wr(8'h30, 32'd0, 4'hF);
      wr(8'h38, 32'd1, 4'h1);
      chk("half0_buzz", {28'd0, buzz}, 32'd0);
      rchk("half0_status", 8'h04, 32'd0);
      wr(8'h00, 32'd2, 4'hF);
      wr(8'h30, 32'd3, 4'hF);
      wr(8'h38, 32'd1, 4'h1);
      chk("gen0_buzz", {28'd0, buzz}, 32'd0);
      rchk("gen0_status", 8'h04, 32'd0);

      // START+STOP in one write while busy
      wr(8'h00, 32'd3, 4'hF);
      wr(8'h14, 32'd0, 4'hF);
      wr(8'h18, 32'd1, 4'h1);
      chk("restart_buzz", {28'd0, buzz}, 32'd1);
      rchk("busy_status", 8'h04, 32'h0000_0001);
      wr(8'h18, 32'd3, 4'h1);
      chk("startstop_buzz", {28'd0, buzz}, 32'd0);
      rchk("startstop_status", 8'h04, 32'd0);

      // all channels running, then GEN=0
      wr(8'h40, 32'd4, 4'hF);
      wr(8'h44, 32'd0, 4'hF);
      wr(8'h18, 32'd1, 4'h1);
      wr(8'h28, 32'd1, 4'h1);
      wr(8'h38, 32'd1, 4'h1);
      wr(8'h48, 32'd1, 4'h1);
      rchk("all_busy", 8'h04, 32'h0000_000F);
      wr(8'h00, 32'd2, 4'hF);
      chk("genoff_buzz", {28'd0, buzz}, 32'd0);
      rchk("genoff_status", 8'h04, 32'd0);

      // asynchronous reset mid-burst with irq pending
      wr(8'h00, 32'd3, 4'hF);
      wr(8'h24, 32'd1, 4'hF);
      wr(8'h28, 32'd1, 4'h1);
      repeat (6) @(negedge clk);
      chk("pre_rst_irq", {31'd0, irq}, 32'd1);
      wr(8'h14, 32'd3, 4'hF);
      wr(8'h18, 32'd1, 4'h1);
      chk("pre_rst_buzz", {28'd0, buzz}, 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_out", {27'd0, irq, buzz}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rchk("post_rst_ctrl", 8'h00, 32'd0);
      rchk("post_rst_half0", 8'h10, 32'd0);
      rchk("post_rst_dur0", 8'h14, 32'd0);
      rchk("post_rst_status", 8'h04, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
